ex_mem_pipe_reg: RTL
====================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Execute->memory pipeline register of the 32-bit core. Captures execute-stage results and control,
//  presents them to the memory stage for one cycle, and supports stall (hold) and flush (bubble).
//  Also drives forwarding/load-use info for the hazard unit.
// PARAMETERS
//  XLEN      32  datapath width (alu result, pc_inc, store data, inst)
//  CNT_W     32  perf counter width (used only with EX_MEM_PERF_CNT_EN)
// PORTS
//  clk                  in   1      core clock, rising edge
//  rst                  in   1      asynchronous, active-high reset
//  i_stall              in   1      hold current contents
//  i_flush              in   1      replace contents with bubble
//  i_valid              in   1      execute stage holds a real instruction
//  i_alu_result         in   XLEN   ALU result / memory address
//  i_inst               in   XLEN   instruction word
//  i_load_store_mode    in   3      funct3 load/store size+sign
//  i_mem_rw             in   1      1 = store
//  i_pc_inc             in   XLEN   PC+4
//  i_pc_sel             in   1      branch/jump taken
//  i_reg_wr_en          in   1      writes rd
//  i_wb_sel             in   2      writeback source (pkg WB_*)
//  i_writedata          in   XLEN   store data (rs2)
//  o_<same names>       out  same   registered copies, names o_alu_result ... o_writedata
//  o_valid              out  1      registered slot holds a real instruction
//  o_fwd_en             out  1      o_fwd_data is forwardable to rs1/rs2 == o_fwd_rd
//  o_fwd_rd             out  5      inst[11:7] of registered instruction
//  o_fwd_data           out  XLEN   o_pc_inc if wb_sel==WB_PC, else o_alu_result
//  o_load_use           out  1      registered inst is a load writing o_fwd_rd (hazard must stall)
//  o_stall_cnt          out  CNT_W  stall cycles (0 without macro)
//  o_flush_cnt          out  CNT_W  flush cycles (0 without macro)
// BEHAVIOUR
//  - Reset (async assert, any time): o_inst=NOP (32'h0000_0013), all other outputs 0, o_valid=0.
//  - Per rising edge, priority rst > i_flush > i_stall > load:
//      flush: bubble = reset values (NOP, valid=0, reg_wr_en=0, mem_rw=0, pc_sel=0).
//      stall: all registers hold; i_* ignored.
//      load : all registers <= i_*; o_valid <= i_valid.
//  - Flush and stall same cycle: flush wins (bubble inserted, stall ignored).
//  - i_valid=0 on load: control bits (mem_rw, reg_wr_en, pc_sel) captured as 0, datapath still captured.
//  - Latency 1 cycle input->output; no combinational path i_* -> o_*.
//  - Forwarding (combinational from registers):
//      o_fwd_en   = o_valid & o_reg_wr_en & (o_fwd_rd!=0) & (o_wb_sel!=WB_MEM)
//      o_load_use = o_valid & o_reg_wr_en & (o_fwd_rd!=0) & (o_wb_sel==WB_MEM)
//      o_fwd_en and o_load_use are never both 1.
//  - rd==x0 never forwards nor flags load-use.
// CONFIGURATION
//  EX_MEM_PERF_CNT_EN defined: two CNT_W counters, reset 0; o_stall_cnt += 1 on each edge with
//   i_stall & ~i_flush; o_flush_cnt += 1 on each edge with i_flush; both saturate at all-ones.
//  Undefined: counters not built, o_stall_cnt/o_flush_cnt tied to 0; ports remain.
// STRUCTURE
//  Package klp32_pkg: XLEN, NOP_INST=32'h0000_0013, wb_sel_e {WB_MEM=2'b00, WB_ALU=2'b01, WB_PC=2'b10},
//   ls_mode_e (LB,LH,LW,LBU,LHU,SB,SH,SW funct3 codes), ex_mem_t struct bundling all registered fields.
//  Sub-module: sat_counter (CNT_W, inc, async rst) instantiated twice under the macro.
//  Register bank is one ex_mem_t always_ff; forwarding logic is always_comb in this module.
// TESTING
//  1 Reset mid-load: rst=1 while i_valid=1, i_alu_result=32'h1234 -> o_inst=32'h13, o_alu_result=0, o_valid=0 immediately.
//  2 Load: i_alu_result=32'h8000_0004, i_reg_wr_en=1, i_wb_sel=WB_ALU, inst rd=5 -> next cycle o_fwd_en=1, o_fwd_rd=5, o_fwd_data=32'h8000_0004.
//  3 Stall 3 cycles with changing inputs -> outputs unchanged; with macro o_stall_cnt=3.
//  4 Flush+stall same edge after valid store (mem_rw=1) -> o_mem_rw=0, o_valid=0, o_inst=NOP; with macro o_flush_cnt=1, o_stall_cnt unchanged.
//  5 Load inst (WB_MEM, rd=7) -> o_load_use=1, o_fwd_en=0; same with rd=0 -> both 0.
//  6 JAL (WB_PC, pc_inc=32'h104, alu=32'h200, rd=1) -> o_fwd_data=32'h104, o_pc_sel passed through.

Source files
------------

// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared types for the klp32 execute->memory stage: widths, the NOP encoding,
// writeback-source codes, load/store funct3 codes and the pipeline register bundle.
package klp32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC  = 2'b10
  } wb_sel_e;

  // Load and store funct3 codes overlap (LB/SB, LH/SH, LW/SW), so they cannot
  // share one enum; i_mem_rw tells them apart.
  typedef logic [2:0] ls_mode_e;
  localparam ls_mode_e LB  = 3'b000;
  localparam ls_mode_e LH  = 3'b001;
  localparam ls_mode_e LW  = 3'b010;
  localparam ls_mode_e LBU = 3'b100;
  localparam ls_mode_e LHU = 3'b101;
  localparam ls_mode_e SB  = 3'b000;
  localparam ls_mode_e SH  = 3'b001;
  localparam ls_mode_e SW  = 3'b010;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] inst;
    ls_mode_e        load_store_mode;
    logic            mem_rw;
    logic [XLEN-1:0] pc_inc;
    logic            pc_sel;
    logic            reg_wr_en;
    wb_sel_e         wb_sel;
    logic [XLEN-1:0] writedata;
  } ex_mem_t;

  // Empty slot: used both at reset and when the stage is flushed.
  function automatic ex_mem_t bubble();
    ex_mem_t b;
    b                 = '0;
    b.inst            = NOP_INST;
    b.wb_sel          = WB_MEM;
    return b;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// Execute->memory bus: execute-side inputs, registered memory-side outputs,
// forwarding/hazard info and perf counters.
// master = execute stage / bench side, slave = the pipeline register.
interface ex_mem_pipe_reg_if
  import klp32_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic            i_stall;
  logic            i_flush;
  logic            i_valid;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_inst;
  logic [2:0]      i_load_store_mode;
  logic            i_mem_rw;
  logic [XLEN-1:0] i_pc_inc;
  logic            i_pc_sel;
  logic            i_reg_wr_en;
  logic [1:0]      i_wb_sel;
  logic [XLEN-1:0] i_writedata;

  logic            o_valid;
  logic [XLEN-1:0] o_alu_result;
  logic [XLEN-1:0] o_inst;
  logic [2:0]      o_load_store_mode;
  logic            o_mem_rw;
  logic [XLEN-1:0] o_pc_inc;
  logic            o_pc_sel;
  logic            o_reg_wr_en;
  logic [1:0]      o_wb_sel;
  logic [XLEN-1:0] o_writedata;
  logic            o_fwd_en;
  logic [4:0]      o_fwd_rd;
  logic [XLEN-1:0] o_fwd_data;
  logic            o_load_use;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_stall, i_flush, i_valid, i_alu_result, i_inst, i_load_store_mode,
           i_mem_rw, i_pc_inc, i_pc_sel, i_reg_wr_en, i_wb_sel, i_writedata,
    input  o_valid, o_alu_result, o_inst, o_load_store_mode, o_mem_rw, o_pc_inc,
           o_pc_sel, o_reg_wr_en, o_wb_sel, o_writedata, o_fwd_en, o_fwd_rd,
           o_fwd_data, o_load_use, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_alu_result, i_inst, i_load_store_mode,
           i_mem_rw, i_pc_inc, i_pc_sel, i_reg_wr_en, i_wb_sel, i_writedata,
    output o_valid, o_alu_result, o_inst, o_load_store_mode, o_mem_rw, o_pc_inc,
           o_pc_sel, o_reg_wr_en, o_wb_sel, o_writedata, o_fwd_en, o_fwd_rd,
           o_fwd_data, o_load_use, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/ex_mem_pipe_reg_sat_counter.sv
// Saturating up-counter for the stage's perf statistics.
// Only compiled when EX_MEM_PERF_CNT_EN is defined; otherwise nothing uses it
// and leaving it out keeps the default build free of an orphan module.
`ifdef EX_MEM_PERF_CNT_EN
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step on inc, stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Count register with async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule
`endif

// File: rtl/ex_mem_pipe_reg.sv
// Execute->memory pipeline register with stall (hold) and flush (bubble),
// plus forwarding / load-use outputs for the hazard unit.
// Optional: EX_MEM_PERF_CNT_EN builds saturating stall/flush cycle counters;
// without it o_stall_cnt/o_flush_cnt read 0.
module ex_mem_pipe_reg
  import klp32_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  ex_mem_pipe_reg_if.slave   bus
);

  ex_mem_t reg_q, reg_d, load_d;
  logic [4:0] fwd_rd;
  logic       rd_wr;

  // Captured slot for a normal load; control bits are dropped for non-valid slots
  // so a stray write/store/redirect can never leak from a dead instruction.
  always_comb begin
    load_d                 = bubble();
    load_d.valid           = bus.i_valid;
    load_d.alu_result      = bus.i_alu_result;
    load_d.inst            = bus.i_inst;
    load_d.load_store_mode = bus.i_load_store_mode;
    load_d.mem_rw          = bus.i_mem_rw & bus.i_valid;
    load_d.pc_inc          = bus.i_pc_inc;
    load_d.pc_sel          = bus.i_pc_sel & bus.i_valid;
    load_d.reg_wr_en       = bus.i_reg_wr_en & bus.i_valid;
    load_d.wb_sel          = wb_sel_e'(bus.i_wb_sel);
    load_d.writedata       = bus.i_writedata;
  end

  // Next-state select: flush beats stall beats load.
  always_comb begin
    reg_d = load_d;
    if (bus.i_flush)      reg_d = bubble();
    else if (bus.i_stall) reg_d = reg_q;
  end

  // Pipeline register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reg_q <= bubble();
    else     reg_q <= reg_d;
  end

  assign bus.o_valid           = reg_q.valid;
  assign bus.o_alu_result      = reg_q.alu_result;
  assign bus.o_inst            = reg_q.inst;
  assign bus.o_load_store_mode = reg_q.load_store_mode;
  assign bus.o_mem_rw          = reg_q.mem_rw;
  assign bus.o_pc_inc          = reg_q.pc_inc;
  assign bus.o_pc_sel          = reg_q.pc_sel;
  assign bus.o_reg_wr_en       = reg_q.reg_wr_en;
  assign bus.o_wb_sel          = reg_q.wb_sel;
  assign bus.o_writedata       = reg_q.writedata;

  // Forwarding / load-use from registered state only; x0 is never a producer.
  always_comb begin
    fwd_rd         = reg_q.inst[11:7];
    rd_wr          = reg_q.valid & reg_q.reg_wr_en & (fwd_rd != 5'd0);
    bus.o_fwd_rd   = fwd_rd;
    bus.o_fwd_en   = rd_wr & (reg_q.wb_sel != WB_MEM);
    bus.o_load_use = rd_wr & (reg_q.wb_sel == WB_MEM);
    bus.o_fwd_data = (reg_q.wb_sel == WB_PC) ? reg_q.pc_inc : reg_q.alu_result;
  end

`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // A stall that coincides with a flush is not a stall cycle.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.i_stall & ~bus.i_flush),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bus.i_flush),
    .cnt (flush_cnt)
  );

  assign bus.o_stall_cnt = stall_cnt;
  assign bus.o_flush_cnt = flush_cnt;
`else
  assign bus.o_stall_cnt = {CNT_W{1'b0}};
  assign bus.o_flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
